// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Sequential instruction fetcher with a credit-limited in-order
//            buffer and single-cycle redirect flushing.
// Options  : FETCH_ALIGN_CHECK_EN - trap misaligned redirects into FAULT and
//            expose the sticky fetch_fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2             // 2 or 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int c_pw = $clog2(BUF_DEPTH);
    localparam logic [c_pw+1:0] c_depth = (c_pw + 2)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic            r_inflight;
    logic [31:0]     r_inflight_pc;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw:0]   r_count;
    logic [31:0]     r_buf_instr [BUF_DEPTH];
    logic [31:0]     r_buf_pc    [BUF_DEPTH];

    logic            w_pop;
    logic            w_push;
    logic [c_pw+1:0] w_credit;
    logic [31:0]     w_target;
    logic            w_fault_hit;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            r_fetch_fault;
    assign fetch_fault = r_fetch_fault;
`endif

    always_comb begin
        instr_valid = (r_count != '0);
        w_pop       = instr_valid & instr_ready;
        // A response arriving in a redirect cycle belongs to the old path.
        w_push      = r_inflight & ~redirect_valid;
        w_target    = redirect_pc & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
        w_fault_hit = redirect_valid && (r_state == S_RUN) && (redirect_pc[1:0] != 2'b00);
`else
        w_fault_hit = 1'b0;
`endif
        // Outstanding entries (buffered + in flight) after this cycle's pop.
        w_credit = {1'b0, r_count}
                 + {{(c_pw + 1){1'b0}}, r_inflight}
                 - {{(c_pw + 1){1'b0}}, w_pop};
        rom_en   = (r_state == S_RUN) && !redirect_valid && (w_credit < c_depth);
        rom_addr = r_pc;
        instr    = instr_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
        instr_pc = instr_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fetch_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                S_RUN:   r_state <= w_fault_hit ? S_FAULT : S_RUN;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_BOOT;
            endcase

            r_inflight <= rom_en;
            if (rom_en) begin
                r_inflight_pc <= r_pc;
            end

            if (redirect_valid) begin
                r_pc     <= w_target;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (w_fault_hit) begin
                    r_fetch_fault <= 1'b1;
                end
`endif
            end else begin
                if (rom_en) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_pw'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_pw'(1);
                end
                r_count <= r_count + {{c_pw{1'b0}}, w_push} - {{c_pw{1'b0}}, w_pop};
            end
        end
    end

    // Storage needs no reset: outputs are gated by instr_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= rom_dout;
            r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// Testbench for instruction_fetch_unit: directed stimulus, queue scoreboard.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_dout = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // ROM: word i holds value i; data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_en) rom_dout <= {2'b00, rom_addr[31:2]};
    end

    function automatic logic [63:0] exp_of(input logic [31:0] pc);
        return {pc, 2'b00, pc[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_transfer: got pc=%h instr=%h required none", instr_pc, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    failures++;
                    $display("FAIL transfer: got pc=%h instr=%h required pc=%h instr=%h",
                             instr_pc, instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Run until the scoreboard empties, then drop ready right after the last transfer.
    task automatic drain(input int max_cycles, input bit check_gap);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            if (check_gap) chk("no_gap_valid", {31'b0, instr_valid}, 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        instr_ready = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    task automatic redirect_end();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_en",      {31'b0, rom_en},      32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr",       instr,                32'h0);
        chk("rst_instr_pc",    instr_pc,             32'h0);
        chk("rst_rom_addr",    rom_addr,             32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_fault",       {31'b0, fetch_fault}, 32'd0);
`endif

        // Reset release, boot cycle, first issue, first visible instruction.
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("boot_rom_en", {31'b0, rom_en}, 32'd0);
        @(negedge clk);
        chk("first_rom_en",   {31'b0, rom_en}, 32'd1);
        chk("first_rom_addr", rom_addr,        32'h0);
        @(negedge clk);
        chk("resp_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("second_rom_addr",  rom_addr,             32'h4);
        @(negedge clk);
        chk("visible_valid", {31'b0, instr_valid}, 32'd1);
        chk("visible_pc",    instr_pc,             32'h0);
        chk("visible_instr", instr,                32'h0);

        // Stalled consumer: buffer fills, issue stops, head stays put.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_rom_en", {31'b0, rom_en},      32'd0);
            chk("stall_valid",  {31'b0, instr_valid}, 32'd1);
            chk("stall_pc",     instr_pc,             32'h0);
        end

        // Resume with ready high: 0,4,...,36 back to back.
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_of(32'(i * 4)));
        @(posedge clk);
        #1 instr_ready = 1'b1;
        drain(30, 1'b1);
        repeat (4) @(posedge clk);

        // Redirect with a full buffer, then again with a fetch in flight.
        redirect_to(32'h100);
        @(negedge clk);
        chk("redir_rom_en", {31'b0, rom_en}, 32'd0);
        redirect_end();
        @(negedge clk);
        chk("redir_issue_en",   {31'b0, rom_en},      32'd1);
        chk("redir_issue_addr", rom_addr,             32'h100);
        chk("redir_flushed",    {31'b0, instr_valid}, 32'd0);
        redirect_to(32'h200);
        @(negedge clk);
        chk("redir2_rom_en", {31'b0, rom_en}, 32'd0);
        redirect_end();
        @(negedge clk);
        chk("no_stale_push",    {31'b0, instr_valid}, 32'd0);
        chk("redir2_issue_addr", rom_addr,            32'h200);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_of(32'h200 + 32'(i * 4)));
        instr_ready = 1'b1;
        drain(30, 1'b0);
        repeat (4) @(posedge clk);

        // Redirect coincident with a pop of 0x210, then stream across the wrap.
        exp_q.push_back(exp_of(32'h210));
        exp_q.push_back(exp_of(32'hFFFF_FFF8));
        exp_q.push_back(exp_of(32'hFFFF_FFFC));
        exp_q.push_back(exp_of(32'h0000_0000));
        exp_q.push_back(exp_of(32'h0000_0004));
        @(posedge clk);
        #1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        redirect_end();
        drain(30, 1'b0);
        repeat (4) @(posedge clk);

        // Misaligned redirect.
        redirect_to(32'h102);
        redirect_end();
`ifdef FETCH_ALIGN_CHECK_EN
        @(negedge clk);
        chk("fault_set", {31'b0, fetch_fault}, 32'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_rom_en", {31'b0, rom_en},      32'd0);
            chk("fault_valid",  {31'b0, instr_valid}, 32'd0);
            chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
        end
        instr_ready = 1'b0;
`else
        exp_q.push_back(exp_of(32'h100));
        exp_q.push_back(exp_of(32'h104));
        instr_ready = 1'b1;
        drain(30, 1'b0);
`endif

        // Mid-operation reset drops everything; fetch restarts at RESET_PC.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_valid",  {31'b0, instr_valid}, 32'd0);
        chk("rst2_rom_en", {31'b0, rom_en},      32'd0);
        chk("rst2_pc",     instr_pc,             32'h0);
        chk("rst2_addr",   rom_addr,             32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst2_fault",  {31'b0, fetch_fault}, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_boot_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_of(32'(i * 4)));
        instr_ready = 1'b1;
        drain(30, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
